// File: rtl/dds_param_ctrl.sv
// DDS runtime parameter controller: turns one-hot key rises into waveform, tuning word
// and step updates, with registered outputs and one-cycle update/saturation strobes.
module dds_param_ctrl #(
   parameter int unsigned     FW_W   = 32,
   parameter logic [FW_W-1:0] F_INIT = 32'd85899,
   parameter logic [FW_W-1:0] F_MIN  = 32'd1,
   parameter logic [FW_W-1:0] F_MAX  = 32'h7FFF_FFFF,
   parameter logic [FW_W-1:0] STEP0  = 32'd8590,
   parameter logic [FW_W-1:0] STEP1  = 32'd85899,
   parameter logic [FW_W-1:0] STEP2  = 32'd858993,
   parameter logic [FW_W-1:0] STEP3  = 32'd8589935
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [3:0]      key_cmd,
   output logic [1:0]      wave_sel,
   output logic [FW_W-1:0] freq_word,
   output logic [1:0]      step_sel,
   output logic            param_upd,
   output logic            sat
);

   function automatic logic [FW_W-1:0] step_lut(input logic [1:0] sel);
      case (sel)
         2'd0:    step_lut = STEP0;
         2'd1:    step_lut = STEP1;
         2'd2:    step_lut = STEP2;
         2'd3:    step_lut = STEP3;
         default: step_lut = STEP0;
      endcase
   endfunction

   logic [3:0]      r_key_d;
   logic [1:0]      r_wave;
   logic [FW_W-1:0] r_freq;
   logic [1:0]      r_step;
   logic            r_upd;
   logic            r_sat;

   logic [3:0]      w_rise;
   logic            w_onehot;
   logic [FW_W-1:0] w_step;
   logic [FW_W:0]   w_sum;
   logic [FW_W:0]   w_floor;
   logic [1:0]      w_wave_nxt;
   logic [FW_W-1:0] w_freq_nxt;
   logic [1:0]      w_step_nxt;
   logic            w_upd_nxt;
   logic            w_sat_nxt;

   // Edge detect and next-parameter computation; limits compared one bit wider to catch overflow
   always_comb begin
      w_rise     = key_cmd & ~r_key_d;
      w_onehot   = (w_rise != 4'b0000) && ((w_rise & (w_rise - 4'd1)) == 4'b0000);
      w_step     = step_lut(r_step);
      w_sum      = {1'b0, r_freq} + {1'b0, w_step};
      w_floor    = {1'b0, F_MIN} + {1'b0, w_step};
      w_wave_nxt = r_wave;
      w_freq_nxt = r_freq;
      w_step_nxt = r_step;
      w_upd_nxt  = 1'b0;
      w_sat_nxt  = 1'b0;
      if (w_onehot) begin
         case (w_rise)
            4'b0001: begin
               w_wave_nxt = r_wave + 2'd1;
               w_upd_nxt  = 1'b1;
            end
            4'b1000: begin
               w_step_nxt = r_step + 2'd1;
               w_upd_nxt  = 1'b1;
            end
            4'b0010: begin
               if (w_sum <= {1'b0, F_MAX}) begin
                  w_freq_nxt = w_sum[FW_W-1:0];
                  w_upd_nxt  = 1'b1;
               end else if (r_freq < F_MAX) begin
                  w_freq_nxt = F_MAX;
                  w_upd_nxt  = 1'b1;
                  w_sat_nxt  = 1'b1;
               end else begin
                  w_sat_nxt  = 1'b1;
               end
            end
            4'b0100: begin
               if ({1'b0, r_freq} >= w_floor) begin
                  w_freq_nxt = r_freq - w_step;
                  w_upd_nxt  = 1'b1;
               end else if (r_freq > F_MIN) begin
                  w_freq_nxt = F_MIN;
                  w_upd_nxt  = 1'b1;
                  w_sat_nxt  = 1'b1;
               end else begin
                  w_sat_nxt  = 1'b1;
               end
            end
            default: begin
               w_upd_nxt = 1'b0;
               w_sat_nxt = 1'b0;
            end
         endcase
      end else begin
         w_upd_nxt = 1'b0;
         w_sat_nxt = 1'b0;
      end
   end

   // Parameter and strobe registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_key_d <= 4'b0000;
         r_wave  <= 2'd0;
         r_freq  <= F_INIT;
         r_step  <= 2'd0;
         r_upd   <= 1'b0;
         r_sat   <= 1'b0;
      end else begin
         r_key_d <= key_cmd;
         r_wave  <= w_wave_nxt;
         r_freq  <= w_freq_nxt;
         r_step  <= w_step_nxt;
         r_upd   <= w_upd_nxt;
         r_sat   <= w_sat_nxt;
      end
   end

   assign wave_sel  = r_wave;
   assign freq_word = r_freq;
   assign step_sel  = r_step;
   assign param_upd = r_upd;
   assign sat       = r_sat;

endmodule

// File: tb/tb_dds_param_ctrl.sv
// Scoreboard bench for dds_param_ctrl: the driver pushes per-cycle expectations from an
// arithmetic reference model; a monitor pops and compares one cycle after each sampling edge.
module tb_dds_param_ctrl;

   localparam longint F_INIT = 64'd85899;
   localparam longint F_MIN  = 64'd1;
   localparam longint F_MAX  = 64'h7FFF_FFFF;

   logic        clk;
   logic        rstn;
   logic [3:0]  key_cmd;
   logic [1:0]  wave_sel;
   logic [31:0] freq_word;
   logic [1:0]  step_sel;
   logic        param_upd;
   logic        sat;

   int total;
   int bad;

   logic [37:0] exp_q[$];

   // reference model state
   int     m_wave;
   int     m_step;
   longint m_freq;
   logic [3:0] m_key_d;

   dds_param_ctrl dut (
      .clk       (clk),
      .rstn      (rstn),
      .key_cmd   (key_cmd),
      .wave_sel  (wave_sel),
      .freq_word (freq_word),
      .step_sel  (step_sel),
      .param_upd (param_upd),
      .sat       (sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic longint step_of(input int s);
      case (s)
         0:       step_of = 64'd8590;
         1:       step_of = 64'd85899;
         2:       step_of = 64'd858993;
         default: step_of = 64'd8589935;
      endcase
   endfunction

   task automatic model_reset();
      m_wave  = 0;
      m_step  = 0;
      m_freq  = F_INIT;
      m_key_d = 4'b0000;
   endtask

   // Apply one key value at the falling edge and queue what the next rising edge must produce.
   task automatic drive(input logic [3:0] k);
      logic [3:0] rise;
      logic       upd;
      logic       st;
      longint     nf;
      @(negedge clk);
      key_cmd = k;
      rise = k & ~m_key_d;
      m_key_d = k;
      upd = 1'b0;
      st  = 1'b0;
      if ($countones(rise) == 1) begin
         if (rise[0]) begin
            m_wave = (m_wave + 1) % 4;
            upd = 1'b1;
         end else if (rise[3]) begin
            m_step = (m_step + 1) % 4;
            upd = 1'b1;
         end else if (rise[1]) begin
            nf = m_freq + step_of(m_step);
            if (nf > F_MAX) begin
               st = 1'b1;
               nf = F_MAX;
            end
            upd = (nf != m_freq);
            m_freq = nf;
         end else begin
            nf = m_freq - step_of(m_step);
            if (nf < F_MIN) begin
               st = 1'b1;
               nf = F_MIN;
            end
            upd = (nf != m_freq);
            m_freq = nf;
         end
      end
      exp_q.push_back({2'(m_wave), 32'(m_freq), 2'(m_step), upd, st});
   endtask

   task automatic pulse(input logic [3:0] k);
      drive(k);
      drive(4'b0000);
   endtask

   task automatic check_reset_vals(input string name);
      total++;
      if (wave_sel !== 2'd0 || freq_word !== 32'd85899 || step_sel !== 2'd0 ||
          param_upd !== 1'b0 || sat !== 1'b0) begin
         bad++;
         $display("FAIL %s: got wave=%0d freq=%0d step=%0d upd=%0b sat=%0b, want 0/85899/0/0/0",
                  name, wave_sel, freq_word, step_sel, param_upd, sat);
      end
   endtask

   // Async reset in the middle of a cycle, checked before any clock edge.
   task automatic async_reset(input logic [3:0] k_release);
      @(negedge clk);
      #2;
      rstn = 1'b0;
      #1;
      check_reset_vals("async_reset");
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      check_reset_vals("reset_held");
      rstn = 1'b1;
      key_cmd = k_release;
   endtask

   // Monitor: compare the DUT with the oldest queued expectation after each rising edge.
   initial begin
      logic [37:0] e;
      logic [37:0] a;
      forever begin
         @(posedge clk);
         #1;
         if (rstn && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {wave_sel, freq_word, step_sel, param_upd, sat};
            total++;
            if (a !== e) begin
               bad++;
               $display("FAIL scoreboard @%0t: got wave=%0d freq=%0d step=%0d upd=%0b sat=%0b, want wave=%0d freq=%0d step=%0d upd=%0b sat=%0b",
                        $time, a[37:36], a[35:4], a[3:2], a[1], a[0],
                        e[37:36], e[35:4], e[3:2], e[1], e[0]);
            end
         end
      end
   end

   initial begin
      int guard;
      total   = 0;
      bad     = 0;
      rstn    = 1'b0;
      key_cmd = 4'b0000;
      model_reset();
      #12;
      check_reset_vals("power_on_reset");
      @(negedge clk);
      rstn = 1'b1;

      repeat (100) drive(4'b0000);

      // waveform key held long, four presses
      for (int p = 0; p < 4; p++) begin
         repeat (50) drive(4'b0001);
         repeat (5) drive(4'b0000);
      end

      pulse(4'b0010);
      pulse(4'b0100);

      // largest step, then clamp at the bottom and refuse below it
      repeat (3) pulse(4'b1000);
      pulse(4'b0100);
      pulse(4'b0100);

      // climb to the top, clamp, then refuse
      guard = 0;
      while (m_freq != F_MAX && guard < 400) begin
         pulse(4'b0010);
         guard++;
      end
      pulse(4'b0010);
      pulse(4'b0010);

      // multi-hot rise is ignored
      drive(4'b0110);
      drive(4'b0110);
      drive(4'b0000);
      drive(4'b1001);
      drive(4'b0000);

      async_reset(4'b0001);
      exp_q.push_back({2'd1, 32'd85899, 2'd0, 1'b1, 1'b0});
      m_wave  = 1;
      m_key_d = 4'b0001;
      repeat (10) drive(4'b0001);
      drive(4'b0000);

      // randomized keys, biased toward single keys and idle cycles
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2: drive(4'b0000);
            3:       drive(4'b0001);
            4, 5:    drive(4'b0010);
            6, 7:    drive(4'b0100);
            8:       drive(4'b1000);
            default: drive(4'($urandom_range(0, 15)));
         endcase
         if (i == 1500) begin
            async_reset(4'b0000);
            exp_q.push_back({2'd0, 32'd85899, 2'd0, 1'b0, 1'b0});
         end
      end

      guard = 0;
      while (exp_q.size() > 0 && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      #2;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
